aes_mixcol_engine: RTL
======================

# aes_mixcol_engine

Parametrised, handshaked MixColumns / InvMixColumns unit for the AES datapath. It accepts one 128-bit state per transaction and applies either the forward or the inverse column transform, or passes the state through (bypass, used for the final round). It processes COLS_PER_CYCLE columns per clock, trading area for latency. It sits between ShiftRows/InvShiftRows and AddRoundKey in the iterative round controller.

## Interface
- COLS_PER_CYCLE, 1, columns transformed per clock.
  - Legal values are 1, 2 or 4; any other value must fail elaboration.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_state, in_mode and in_bypass are valid.
- in_ready  out  1  engine can accept a state this cycle.
- in_state  in  128  column-major state: byte s0 = [127:120] … s15 = [7:0]; column c = bits [127-32c -: 32], row 0 in its MSB byte.
- in_mode  in  1  0 = MixColumns, 1 = InvMixColumns.
- in_bypass  in  1  1 = output equals input (no transform).
- out_valid  out  1  out_state holds a result.
- out_ready  in  1  consumer accepts out_state.
- out_state  out  128  result, same byte ordering as in_state.

## Operation
- Derived constant: NCYC = 4 / COLS_PER_CYCLE.
- FSM states:
  - IDLE: in_ready = 1.
    - Accept on in_valid && in_ready: latch in_state into the working register, and latch in_mode and in_bypass.
    - Clear the column counter.
    - Go to DONE if in_bypass, else to BUSY.
  - BUSY: each cycle, transform columns [cnt*COLS_PER_CYCLE, +COLS_PER_CYCLE) in place and increment cnt.
    - When the last group has been written (cnt == NCYC-1), go to DONE.
  - DONE: out_valid = 1 and out_state = working register.
    - On out_ready, go to IDLE.
    - out_state stays stable while out_valid && !out_ready.
- in_ready = (state == IDLE) && !rst. No acceptance is possible in BUSY or DONE; input is ignored there.
- Forward transform per column (a0..a3 → b0..b3), GF(2^8) with polynomial 0x11B, xtime(x) = (x<<1) ^ (x[7] ? 0x1B : 0):
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
- Inverse transform uses the coefficient rows {0E,0B,0D,09}, {09,0E,0B,0D}, {0D,09,0E,0B}, {0B,0D,09,0E}.
  - Multiplies are built only from xtime chains and XOR.
  - No lookup tables, no `*` operator.
- The per-column datapath is instantiated exactly COLS_PER_CYCLE times. The column group is selected by cnt via a mux.
- Mode and bypass are sampled only at acceptance; changes while BUSY or DONE have no effect.
- All arithmetic is 8-bit XOR; there is no carry and no width growth.

## Timing
- Reset values (state after any clock with rst = 1): state = IDLE, out_valid = 0, out_state = 128'h0, cnt = 0, latched mode and bypass = 0. in_ready = 0 while rst is high.
- rst asserted in any state, including mid-BUSY or DONE with !out_ready: the in-flight state is discarded. IDLE is reached the next cycle with no out_valid pulse.
- Latency, acceptance edge to first cycle with out_valid = 1:
  - normal: NCYC + 1 clocks (COLS_PER_CYCLE = 4 → 2, 2 → 3, 1 → 5);
  - bypass: 1 clock.
- Throughput: one state every NCYC + 2 clocks with out_ready held high (bypass: every 2). The DONE→IDLE handshake cycle is never overlapped with a new acceptance.
- out_valid falls on the clock edge after the out_valid && out_ready cycle.
- cnt wraps to 0 on entry to BUSY only, never by overflow.
- out_state is registered; no combinational path from in_* to out_*.

## Test plan
1. FIPS-197 round-1 state, mode 0, each COLS_PER_CYCLE.
   - Stimulus: in_state = d4bf5d30e0b452aeb84111f11e2798e5.
   - Required: out_state = 046681e5e0cb199a48f8d37a2806264c, with out_valid after exactly NCYC + 1 clocks.
2. Inverse round trip.
   - Stimulus: mode 1 with in_state = 046681e5e0cb199a48f8d37a2806264c.
   - Required: out_state = d4bf5d30e0b452aeb84111f11e2798e5.
3. Known columns, mode 0.
   - Stimulus: db135345 f20a225c 01010101 2d26314c.
   - Required: out_state = 8e4da1bc 9fdc589d 01010101 4d7ebdf8.
4. Bypass and backpressure.
   - Stimulus: in_bypass = 1, arbitrary in_state, out_ready held low for 5 clocks.
   - Required:
     - out_valid rises 1 clock after acceptance;
     - out_state equals in_state and stays stable;
     - in_ready stays 0 until the cycle after out_ready rises.
5. Mid-operation reset.
   - Stimulus: with COLS_PER_CYCLE = 1, assert rst on the 2nd BUSY clock.
   - Required:
     - out_valid never asserts for that state;
     - out_state = 0 and in_ready = 0 during rst, then 1 the cycle after it falls;
     - the next transaction yields the correct result.
6. Input ignored while busy.
   - Stimulus: toggle in_mode and in_state and hold in_valid high during BUSY and DONE.
   - Required: the result reflects only the originally accepted state and mode, and exactly one out_valid pulse per acceptance.

Source files
------------

// File: rtl/aes_mixcol_engine.sv
// -----------------------------------------------------------------------------
// aes_mixcol_engine
//
// Handshaked AES MixColumns / InvMixColumns unit. It accepts one 128-bit state
// per transaction and applies the forward column transform, the inverse column
// transform, or passes the state through unchanged (bypass, for the final
// round). COLS_PER_CYCLE columns are transformed per clock, so a transform
// takes 4 / COLS_PER_CYCLE working cycles.
//
// Byte order is column-major: s0 = [127:120] ... s15 = [7:0]. Column c
// occupies [127-32c -: 32], and row 0 is the most significant byte.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   in_state / in_mode / in_bypass are valid
//   in_ready   engine can accept a state this cycle (IDLE and not in reset)
//   in_state   128-bit input state
//   in_mode    0 = MixColumns, 1 = InvMixColumns
//   in_bypass  1 = result equals input, no transform
//   out_valid  out_state holds a result
//   out_ready  consumer accepts out_state
//   out_state  128-bit result, same byte order as in_state
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// aes_mixcol_column
//
// Purely combinational transform of one 32-bit column.
//
// Ports
//   col     input column, row 0 in [31:24]
//   inv     0 = forward MixColumns, 1 = InvMixColumns
//   result  transformed column, row 0 in [31:24]
// -----------------------------------------------------------------------------
module aes_mixcol_column (
  input  logic [31:0] col,
  input  logic        inv,
  output logic [31:0] result
);

  // Multiply by 2 in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a   [4];
  logic [7:0] x2  [4];
  logic [7:0] x4  [4];
  logic [7:0] x8  [4];
  logic [7:0] m3  [4];
  logic [7:0] m9  [4];
  logic [7:0] mb  [4];
  logic [7:0] md  [4];
  logic [7:0] me  [4];
  logic [7:0] fwd [4];
  logic [7:0] bwd [4];

  // Every constant multiple is a XOR of the xtime chain a, 2a, 4a, 8a.
  for (genvar i = 0; i < 4; i++) begin : g_mult
    assign a[i]  = col[31-8*i -: 8];
    assign x2[i] = xtime(a[i]);
    assign x4[i] = xtime(x2[i]);
    assign x8[i] = xtime(x4[i]);
    assign m3[i] = x2[i] ^ a[i];
    assign m9[i] = x8[i] ^ a[i];
    assign mb[i] = x8[i] ^ x2[i] ^ a[i];
    assign md[i] = x8[i] ^ x4[i] ^ a[i];
    assign me[i] = x8[i] ^ x4[i] ^ x2[i];
  end

  // Both matrices are circulant: output row i uses coefficient k on a[(i+k)%4].
  for (genvar i = 0; i < 4; i++) begin : g_row
    localparam int J1 = (i + 1) % 4;
    localparam int J2 = (i + 2) % 4;
    localparam int J3 = (i + 3) % 4;
    assign fwd[i] = x2[i] ^ m3[J1] ^ a[J2]  ^ a[J3];
    assign bwd[i] = me[i] ^ mb[J1] ^ md[J2] ^ m9[J3];
    assign result[31-8*i -: 8] = inv ? bwd[i] : fwd[i];
  end

endmodule

// -----------------------------------------------------------------------------
// State table
//   IDLE | waiting for a state; in_ready high (outside reset)
//   BUSY | transforming one column group per clock in the working register
//   DONE | result presented on out_state; held until out_ready
// -----------------------------------------------------------------------------
module aes_mixcol_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_mode,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4))
  begin : g_bad_cols_per_cycle
    $error("aes_mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int         NCYC     = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] CNT_LAST = 2'(NCYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  cnt;
  logic        mode_q;
  logic        bypass_q;
  logic        accept;
  logic [31:0] work     [4];
  logic [1:0]  grp_base;
  logic [31:0] grp_in   [COLS_PER_CYCLE];
  logic [31:0] grp_out  [COLS_PER_CYCLE];

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          state_next = in_bypass ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (cnt == CNT_LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  // First column of the group being transformed this cycle.
  always_comb begin
    grp_base = 2'd0;
    if (COLS_PER_CYCLE == 1) begin
      grp_base = cnt;
    end else if (COLS_PER_CYCLE == 2) begin
      grp_base = {cnt[0], 1'b0};
    end
  end

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    assign grp_in[k] = work[grp_base + 2'(k)];

    aes_mixcol_column u_col (
      .col    (grp_in[k]),
      .inv    (mode_q),
      .result (grp_out[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      mode_q   <= 1'b0;
      bypass_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        work[i] <= 32'h0;
      end
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (accept) begin
            for (int i = 0; i < 4; i++) begin
              work[i] <= in_state[127-32*i -: 32];
            end
            mode_q   <= in_mode;
            bypass_q <= in_bypass;
            cnt      <= 2'd0;
          end
        end
        BUSY: begin
          // A bypassed state never enters BUSY; the guard keeps the working
          // register untouched should that ever change.
          if (!bypass_q) begin
            for (int k = 0; k < COLS_PER_CYCLE; k++) begin
              work[grp_base + 2'(k)] <= grp_out[k];
            end
          end
          // cnt parks on the last group and is only cleared on acceptance.
          if (cnt != CNT_LAST) begin
            cnt <= cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // The working register is the result register; it is only written in IDLE
  // on acceptance and in BUSY, so it is stable for the whole of DONE.
  assign out_state = {work[0], work[1], work[2], work[3]};

endmodule
